emu_ff_scan_system: RTL and testbench

//   Emulation wrapper around a small user design: four data registers (64/32/8/80 bit) with scan-chain checkpointing.
//   In run mode the registers capture their inputs. In scan mode they form one serial chain the host reads/writes.

---
 rtl/emu_ff_scan_system_if.sv | 40 ++++
 rtl/emu_ff_scan_system.sv | 85 ++++++++
 tb/tb_emu_ff_scan_system.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/emu_ff_scan_system_if.sv
// Host scan-access bundle for emu_ff_scan_system.
// Carries mode, FF chain and RAM scan signals.
interface emu_ff_scan_system_if;
  logic        EMU_RUN_MODE;
  logic        EMU_SCAN_MODE;
  logic        EMU_FF_SE;
  logic        EMU_FF_DI;
  logic        EMU_FF_DO;
  logic        EMU_RAM_SR;
  logic        EMU_RAM_SE;
  logic        EMU_RAM_SD;
  logic [63:0] EMU_RAM_DI;
  logic [63:0] EMU_RAM_DO;

  modport master (
    output EMU_RUN_MODE,
    output EMU_SCAN_MODE,
    output EMU_FF_SE,
    output EMU_FF_DI,
    input  EMU_FF_DO,
    output EMU_RAM_SR,
    output EMU_RAM_SE,
    output EMU_RAM_SD,
    output EMU_RAM_DI,
    input  EMU_RAM_DO
  );

  modport slave (
    input  EMU_RUN_MODE,
    input  EMU_SCAN_MODE,
    input  EMU_FF_SE,
    input  EMU_FF_DI,
    output EMU_FF_DO,
    input  EMU_RAM_SR,
    input  EMU_RAM_SE,
    input  EMU_RAM_SD,
    input  EMU_RAM_DI,
    output EMU_RAM_DO
  );
endinterface

// File: rtl/emu_ff_scan_system.sv
// Emulation wrapper: 184-bit user register chain with scan dump/restore.
// Optional scannable log RAM enabled by `define EMU_RAM_SCAN_EN.
module emu_ff_scan_system (
  input  logic                 EMU_HOST_CLK,
  input  logic                 rst_n,
  emu_ff_scan_system_if.slave  scan,
  input  logic [63:0]          d1,
  input  logic [31:0]          d2,
  input  logic [7:0]           d3,
  input  logic [79:0]          d4,
  output logic [63:0]          q1,
  output logic [31:0]          q2,
  output logic [7:0]           q3,
  output logic [79:0]          q4
);
  localparam int FF_BIT_COUNT = 184;

  logic [FF_BIT_COUNT-1:0] chain;
  logic shift_en;
  logic cap_en;

  assign shift_en = scan.EMU_SCAN_MODE & scan.EMU_FF_SE;
  assign cap_en   = ~scan.EMU_SCAN_MODE & scan.EMU_RUN_MODE;

  // Shift wins over capture, so scan mode fully freezes user capture.
  always_ff @(posedge EMU_HOST_CLK or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else if (shift_en) begin
      chain <= {chain[FF_BIT_COUNT-2:0], scan.EMU_FF_DI};
    end else if (cap_en) begin
      chain <= {d1, d2, d3, d4};
    end
  end

  assign q1 = chain[183:120];
  assign q2 = chain[119:88];
  assign q3 = chain[87:80];
  assign q4 = chain[79:0];

  assign scan.EMU_FF_DO = chain[FF_BIT_COUNT-1];

`ifdef EMU_RAM_SCAN_EN
  localparam int RAM_DEPTH = 4;

  logic [63:0] mem [RAM_DEPTH];
  logic [1:0]  wp;
  logic [1:0]  rp;
  logic        step_en;

  assign step_en = scan.EMU_SCAN_MODE & scan.EMU_RAM_SE;

  // Capture logging and scan writes are mutually exclusive via SCAN_MODE.
  always_ff @(posedge EMU_HOST_CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAM_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wp <= '0;
      rp <= '0;
    end else begin
      if (cap_en) begin
        mem[wp] <= d1;
        wp      <= wp + 2'd1;
      end
      if (scan.EMU_RAM_SR) begin
        rp <= '0;
      end else if (step_en) begin
        if (scan.EMU_RAM_SD) begin
          mem[rp] <= scan.EMU_RAM_DI;
        end
        rp <= rp + 2'd1;
      end
    end
  end

  assign scan.EMU_RAM_DO = mem[rp];
`else
  logic ram_unused;

  assign ram_unused = ^{scan.EMU_RAM_SR, scan.EMU_RAM_SE,
                        scan.EMU_RAM_SD, scan.EMU_RAM_DI};
  assign scan.EMU_RAM_DO = '0;
`endif
endmodule

// File: tb/tb_emu_ff_scan_system.sv
// Directed bench for emu_ff_scan_system.
// RAM checks follow the EMU_RAM_SCAN_EN build option.
module tb_emu_ff_scan_system;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] d1;
  logic [31:0] d2;
  logic [7:0]  d3;
  logic [79:0] d4;
  logic [63:0] q1;
  logic [31:0] q2;
  logic [7:0]  q3;
  logic [79:0] q4;

  int pass_cnt = 0;
  int total = 0;

  logic [183:0] orig;
  logic [183:0] saved;
  logic [183:0] chain_now;

  emu_ff_scan_system_if bus ();

  emu_ff_scan_system dut (
    .EMU_HOST_CLK (clk),
    .rst_n        (rst_n),
    .scan         (bus),
    .d1           (d1),
    .d2           (d2),
    .d3           (d3),
    .d4           (d4),
    .q1           (q1),
    .q2           (q2),
    .q3           (q3),
    .q4           (q4)
  );

  always #5 clk = ~clk;

  assign chain_now = {q1, q2, q3, q4};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.EMU_RUN_MODE = 1'b1;
    bus.EMU_SCAN_MODE = 1'b0;
    bus.EMU_FF_SE = 1'b0;
    bus.EMU_FF_DI = 1'b0;
    bus.EMU_RAM_SR = 1'b0;
    bus.EMU_RAM_SE = 1'b0;
    bus.EMU_RAM_SD = 1'b0;
    bus.EMU_RAM_DI = '0;
    d1 = '1; d2 = '1; d3 = '1; d4 = '1;
    step();
    step();
    total++;
    if (chain_now !== 184'd0)
      $display("FAIL reset_q got %h want 0", chain_now);
    else pass_cnt++;
    total++;
    if (bus.EMU_FF_DO !== 1'b0)
      $display("FAIL reset_do got %b want 0", bus.EMU_FF_DO);
    else pass_cnt++;
    total++;
    if (bus.EMU_RAM_DO !== 64'd0)
      $display("FAIL reset_ram_do got %h want 0", bus.EMU_RAM_DO);
    else pass_cnt++;
    rst_n = 1'b1;
    d1 = 64'h0123456789abcdef;
    d2 = '0; d3 = '0; d4 = '0;
    step();
    total++;
    if (q1 !== 64'h0123456789abcdef)
      $display("FAIL reset_capture got %h want 0123456789abcdef", q1);
    else pass_cnt++;
  endtask

  task automatic test_freeze();
    bus.EMU_RUN_MODE = 1'b1;
    d1 = 64'hfedcba9876543210;
    d2 = 32'hdeadbeef;
    d3 = 8'h5a;
    d4 = 80'h0102_0304_0506_0708_090a;
    step();
    total++;
    if (chain_now !== {64'hfedcba9876543210, 32'hdeadbeef, 8'h5a,
                       80'h0102_0304_0506_0708_090a})
      $display("FAIL run_capture got %h", chain_now);
    else pass_cnt++;
    bus.EMU_RUN_MODE = 1'b0;
    d1 = '0; d2 = 32'h1; d3 = 8'hff; d4 = '1;
    step();
    step();
    step();
    total++;
    if (q1 !== 64'hfedcba9876543210)
      $display("FAIL freeze_q1 got %h want fedcba9876543210", q1);
    else pass_cnt++;
    total++;
    if (q2 !== 32'hdeadbeef)
      $display("FAIL freeze_q2 got %h want deadbeef", q2);
    else pass_cnt++;
    total++;
    if (q3 !== 8'h5a)
      $display("FAIL freeze_q3 got %h want 5a", q3);
    else pass_cnt++;
    total++;
    if (q4 !== 80'h0102_0304_0506_0708_090a)
      $display("FAIL freeze_q4 got %h want 0102030405060708090a", q4);
    else pass_cnt++;
  endtask

  task automatic test_dump();
    int shifts;
    int iters;
    logic se;
    orig = {64'h8000_0000_0000_0000, 32'h1234_5678, 8'hc3,
            80'hfeed_0000_beef_1111_2222};
    bus.EMU_RUN_MODE = 1'b1;
    d1 = 64'h8000_0000_0000_0000;
    d2 = 32'h1234_5678;
    d3 = 8'hc3;
    d4 = 80'hfeed_0000_beef_1111_2222;
    step();
    bus.EMU_RUN_MODE = 1'b0;
    total++;
    if (chain_now !== orig)
      $display("FAIL dump_setup got %h want %h", chain_now, orig);
    else pass_cnt++;
    total++;
    if (bus.EMU_FF_DO !== 1'b1)
      $display("FAIL dump_first_do got %b want 1", bus.EMU_FF_DO);
    else pass_cnt++;
    bus.EMU_SCAN_MODE = 1'b1;
    saved = '0;
    shifts = 0;
    iters = 0;
    while (shifts < 184 && iters < 4000) begin
      iters++;
      se = ($urandom_range(0, 3) != 0);
      bus.EMU_FF_SE = se;
      bus.EMU_FF_DI = bus.EMU_FF_DO;
      if (se) saved = {saved[182:0], bus.EMU_FF_DO};
      step();
      if (se) shifts++;
    end
    bus.EMU_FF_SE = 1'b0;
    total++;
    if (shifts != 184)
      $display("FAIL dump_budget got %0d shifts want 184", shifts);
    else pass_cnt++;
    total++;
    if (chain_now !== orig)
      $display("FAIL dump_rotate got %h want %h", chain_now, orig);
    else pass_cnt++;
    total++;
    if (saved !== orig)
      $display("FAIL dump_stream got %h want %h", saved, orig);
    else pass_cnt++;
  endtask

  task automatic test_restore();
    int k;
    int iters;
    logic se;
    bus.EMU_SCAN_MODE = 1'b0;
    bus.EMU_RUN_MODE = 1'b1;
    d1 = 64'h1111_2222_3333_4444;
    d2 = 32'h5555_6666;
    d3 = 8'h77;
    d4 = 80'h8888_9999_aaaa_bbbb_cccc;
    step();
    bus.EMU_RUN_MODE = 1'b0;
    total++;
    if (chain_now !== {64'h1111_2222_3333_4444, 32'h5555_6666, 8'h77,
                       80'h8888_9999_aaaa_bbbb_cccc})
      $display("FAIL restore_overwrite got %h", chain_now);
    else pass_cnt++;
    bus.EMU_SCAN_MODE = 1'b1;
    k = 0;
    iters = 0;
    while (k < 184 && iters < 4000) begin
      iters++;
      se = ($urandom_range(0, 2) != 0);
      bus.EMU_FF_SE = se;
      bus.EMU_FF_DI = saved[183-k];
      step();
      if (se) k++;
    end
    bus.EMU_FF_SE = 1'b0;
    total++;
    if (k != 184)
      $display("FAIL restore_budget got %0d shifts want 184", k);
    else pass_cnt++;
    total++;
    if (chain_now !== orig)
      $display("FAIL restore_state got %h want %h", chain_now, orig);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bus.EMU_SCAN_MODE = 1'b1;
    bus.EMU_FF_SE = 1'b0;
    bus.EMU_RUN_MODE = 1'b1;
    bus.EMU_FF_DI = 1'b1;
    d1 = '0; d2 = '0; d3 = '0; d4 = '0;
    step();
    step();
    step();
    total++;
    if (chain_now !== orig)
      $display("FAIL stall_hold got %h want %h", chain_now, orig);
    else pass_cnt++;
  endtask

  task automatic test_priority();
    bus.EMU_SCAN_MODE = 1'b1;
    bus.EMU_RUN_MODE = 1'b1;
    bus.EMU_FF_SE = 1'b1;
    bus.EMU_FF_DI = 1'b0;
    d1 = '1; d2 = '1; d3 = '1; d4 = '1;
    step();
    bus.EMU_FF_SE = 1'b0;
    bus.EMU_RUN_MODE = 1'b0;
    total++;
    if (chain_now !== {orig[182:0], 1'b0})
      $display("FAIL priority_shift got %h want %h",
               chain_now, {orig[182:0], 1'b0});
    else pass_cnt++;
  endtask

`ifdef EMU_RAM_SCAN_EN
  task automatic test_ram();
    rst_n = 1'b0;
    bus.EMU_SCAN_MODE = 1'b0;
    bus.EMU_RUN_MODE = 1'b0;
    step();
    rst_n = 1'b1;
    total++;
    if (bus.EMU_RAM_DO !== 64'd0)
      $display("FAIL ram_reset got %h want 0", bus.EMU_RAM_DO);
    else pass_cnt++;
    bus.EMU_RUN_MODE = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      d1 = 64'(k);
      step();
    end
    bus.EMU_RUN_MODE = 1'b0;
    bus.EMU_RAM_SR = 1'b1;
    step();
    bus.EMU_RAM_SR = 1'b0;
    bus.EMU_SCAN_MODE = 1'b1;
    bus.EMU_RAM_SE = 1'b1;
    bus.EMU_RAM_SD = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (bus.EMU_RAM_DO !== 64'(k))
        $display("FAIL ram_log_%0d got %h want %h", k, bus.EMU_RAM_DO, 64'(k));
      else pass_cnt++;
      step();
    end
    bus.EMU_RAM_SE = 1'b0;
    bus.EMU_RAM_SR = 1'b1;
    step();
    bus.EMU_RAM_SR = 1'b0;
    bus.EMU_RAM_SE = 1'b1;
    bus.EMU_RAM_SD = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.EMU_RAM_DI = 64'ha5a5_0000_0000_0000 | 64'(k);
      step();
    end
    bus.EMU_RAM_SD = 1'b0;
    bus.EMU_RAM_SE = 1'b0;
    bus.EMU_RAM_SR = 1'b1;
    step();
    bus.EMU_RAM_SR = 1'b0;
    bus.EMU_RAM_SE = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (bus.EMU_RAM_DO !== (64'ha5a5_0000_0000_0000 | 64'(k)))
        $display("FAIL ram_wr_%0d got %h want %h", k, bus.EMU_RAM_DO,
                 64'ha5a5_0000_0000_0000 | 64'(k));
      else pass_cnt++;
      step();
    end
    bus.EMU_RAM_SE = 1'b0;
    bus.EMU_SCAN_MODE = 1'b0;
  endtask
`else
  task automatic test_ram();
    bus.EMU_SCAN_MODE = 1'b1;
    bus.EMU_RAM_SR = 1'b1;
    bus.EMU_RAM_SE = 1'b1;
    bus.EMU_RAM_SD = 1'b1;
    bus.EMU_RAM_DI = 64'hffff_0000_ffff_0000;
    step();
    bus.EMU_RAM_SR = 1'b0;
    step();
    total++;
    if (bus.EMU_RAM_DO !== 64'd0)
      $display("FAIL ram_tied got %h want 0", bus.EMU_RAM_DO);
    else pass_cnt++;
    bus.EMU_RAM_SE = 1'b0;
    bus.EMU_RAM_SD = 1'b0;
    bus.EMU_SCAN_MODE = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_freeze();
    test_dump();
    test_restore();
    test_backpressure();
    test_priority();
    test_ram();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
